msrv32_wb_stage: RTL
====================

Name: msrv32_wb_stage

Overview:
- Write-back stage directly upstream of the integer register file.
- Accepts one retiring instruction per handshake from execute and waits for data-memory acknowledge on loads.
- Aligns and sign-extends load data and selects the write-back source.
- Drives the register file's write address, write data and one-cycle write enable.

Parameters:
WIDTH, 32, datapath width
ADDR_WIDTH, 5, register address width

Ports:
msrv32_mp_clk_in  input  1  clock, rising edge
msrv32_mp_rst_in  input  1  reset, asynchronous, active-low
ex_valid_in  input  1  execute presents a retiring instruction
ex_ready_out  output  1  stage can accept (handshake completes when valid and ready are both high)
flush_in  input  1  discard in-flight instruction
rd_addr_in  input  ADDR_WIDTH  destination register
rf_wr_en_in  input  1  instruction writes rd
wb_sel_in  input  2  source select: 00 ALU, 01 load, 10 imm, 11 pc+4
alu_result_in  input  WIDTH  ALU result; also the load address
imm_in  input  WIDTH  U-type immediate
pc_in  input  WIDTH  instruction PC
load_funct3_in  input  3  load size/sign
dm_rdata_in  input  WIDTH  data-memory read word
dm_ack_in  input  1  data-memory read data valid
rd_addr_out  output  ADDR_WIDTH  to register file
rd_out  output  WIDTH  to register file
wr_en_out  output  1  to register file, one-cycle pulse
stall_out  output  1  high while a load is outstanding
misaligned_out  output  1  misaligned-load pulse (see Optional Feature)

Behaviour:
- Reset (asynchronous, msrv32_mp_rst_in low): state IDLE, all outputs 0, capture registers 0. The FSM holds IDLE while reset is low. Reset mid-load aborts the load with no write.
- FSM states: IDLE, WAIT_ACK. ex_ready_out = (state==IDLE). stall_out = (state==WAIT_ACK).
- IDLE, handshake, wb_sel!=01:
  - rd_out is the selected source: ALU=alu_result_in, imm=imm_in, pc+4=pc_in+4 (mod 2^WIDTH).
  - Registered next edge; wr_en_out pulses for exactly one cycle. Latency 1.
  - State stays IDLE, so back-to-back accepts give back-to-back writes.
- IDLE, handshake, wb_sel==01:
  - Capture rd_addr, rf_wr_en, funct3 and alu_result[1:0].
  - Go to WAIT_ACK. dm_ack_in is ignored while in IDLE.
- WAIT_ACK with dm_ack_in high:
  - Align dm_rdata_in and register it to rd_out.
  - Pulse wr_en_out and return to IDLE.
  - Write occurs the cycle after ack. Minimum load latency is 2 cycles.
- flush_in has priority over ack and over accept:
  - In WAIT_ACK: go to IDLE with no write.
  - In IDLE: a same-cycle handshake is dropped.
  - A wr_en_out pulse already registered is not retracted.
- Write enable rule: wr_en_out = captured rf_wr_en AND rd_addr!=0. Writes to x0 never assert wr_en_out; rd_addr_out/rd_out still update.
- Output persistence: rd_addr_out and rd_out hold their last value between writes. wr_en_out is 0 except for the pulse cycle.
- Load alignment (off = alu_result[1:0]):
  - LB/LBU (000/100): byte off, sign- or zero-extended.
  - LH/LHU (001/101): half selected by off[1], off[0] ignored, sign- or zero-extended.
  - LW (010): full word, off ignored.
  - Reserved funct3 (011, 110, 111): result 0, write still performed.

Optional Feature:
- Macro: MSRV32_WB_MISALIGN_TRAP_EN.
- Defined: a load is misaligned when it is LH/LHU with off[0]=1, or LW with off!=0.
  - On ack, no write is performed.
  - misaligned_out pulses 1 cycle, concurrent with where wr_en_out would have pulsed.
- Undefined: misaligned_out is tied 0; the low-bit ignore rules above apply.

Decomposition:
- Package msrv32_pkg holds:
  - WB_SEL_ALU/LOAD/IMM/PC4 codes.
  - LB/LH/LW/LBU/LHU funct3 constants.
  - The wb_state_t enum {IDLE, WAIT_ACK}.
- One combinational sub-module, msrv32_load_align:
  - Inputs: funct3, off, rdata.
  - Outputs: aligned word, misaligned flag.

Test Plan:
- ALU write: valid, wb_sel=00, rd=5, alu=0x1234, rf_wr_en=1 -> next cycle wr_en_out=1, rd_addr_out=5, rd_out=0x1234; 0 the cycle after.
- Back-to-back writes: wb_sel=11 pc=0x100 rd=1, then wb_sel=10 imm=0xABCD0000 rd=2 -> consecutive pulses: 0x104 to x1, 0xABCD0000 to x2.
- Load LB: off=3, dm_rdata=0x80FF_FF7F, ack 4 cycles later -> ex_ready_out=0 and stall_out=1 while waiting; write 0xFFFFFF80 the cycle after ack. LHU off=2 on the same data -> 0x000080FF.
- Flush and x0: flush_in asserted in WAIT_ACK together with ack -> IDLE, no write. ALU op with rd=0 -> wr_en_out stays 0.
- Misaligned LW, off=1, macro defined -> misaligned_out pulse, no write. Macro undefined -> write full dm_rdata_in.
- Reset mid-load: msrv32_mp_rst_in low in WAIT_ACK (async, between edges) -> outputs 0 immediately, IDLE, no write after release.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 write-back stage: source-select codes,
// load funct3 encodings and the write-back FSM state type.
package msrv32_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_IMM  = 2'b10;
    localparam logic [1:0] WB_SEL_PC4  = 2'b11;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_ACK = 1'b1} wb_state_t;

endpackage

// File: rtl/msrv32_wb_stage_if.sv
// Bundle of execute-side, data-memory and register-file signals of the
// write-back stage; master drives the stage inputs, slave is the stage.
interface msrv32_wb_stage_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ex_valid_in;
    logic                  ex_ready_out;
    logic                  flush_in;
    logic [ADDR_WIDTH-1:0] rd_addr_in;
    logic                  rf_wr_en_in;
    logic [1:0]            wb_sel_in;
    logic [WIDTH-1:0]      alu_result_in;
    logic [WIDTH-1:0]      imm_in;
    logic [WIDTH-1:0]      pc_in;
    logic [2:0]            load_funct3_in;
    logic [WIDTH-1:0]      dm_rdata_in;
    logic                  dm_ack_in;
    logic [ADDR_WIDTH-1:0] rd_addr_out;
    logic [WIDTH-1:0]      rd_out;
    logic                  wr_en_out;
    logic                  stall_out;
    logic                  misaligned_out;

    modport master (
        output ex_valid_in, flush_in, rd_addr_in, rf_wr_en_in, wb_sel_in,
               alu_result_in, imm_in, pc_in, load_funct3_in, dm_rdata_in, dm_ack_in,
        input  ex_ready_out, rd_addr_out, rd_out, wr_en_out, stall_out, misaligned_out
    );

    modport slave (
        input  ex_valid_in, flush_in, rd_addr_in, rf_wr_en_in, wb_sel_in,
               alu_result_in, imm_in, pc_in, load_funct3_in, dm_rdata_in, dm_ack_in,
        output ex_ready_out, rd_addr_out, rd_out, wr_en_out, stall_out, misaligned_out
    );
endinterface

// File: rtl/msrv32_load_align.sv
// Combinational load aligner: picks the byte/half/word at the given offset,
// sign- or zero-extends it, and flags accesses that are not naturally aligned.
module msrv32_load_align
    import msrv32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [1:0]       off,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] aligned,
    output logic             misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (off)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        aligned    = '0;
        misaligned = 1'b0;
        case (funct3)
            LB:  aligned = {{(WIDTH-8){byte_v[7]}}, byte_v};
            LBU: aligned = {{(WIDTH-8){1'b0}}, byte_v};
            LH: begin
                aligned    = {{(WIDTH-16){half_v[15]}}, half_v};
                misaligned = off[0];
            end
            LHU: begin
                aligned    = {{(WIDTH-16){1'b0}}, half_v};
                misaligned = off[0];
            end
            LW: begin
                aligned    = rdata;
                misaligned = (off != 2'd0);
            end
            default: aligned = '0;
        endcase
    end

endmodule

// File: rtl/msrv32_wb_stage.sv
// Write-back stage feeding the integer register file. Build with
// MSRV32_WB_MISALIGN_TRAP_EN defined to suppress misaligned-load writes.
module msrv32_wb_stage
    import msrv32_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic              msrv32_mp_clk_in,
    input  logic              msrv32_mp_rst_in,
    msrv32_wb_stage_if.slave  wb,
    output wb_state_t         state_dbg
);

    localparam logic [0:0] S_IDLE     = IDLE;
    localparam logic [0:0] S_WAIT_ACK = WAIT_ACK;

`ifdef MSRV32_WB_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] cap_rd;
    logic                  cap_wen;
    logic [2:0]            cap_f3;
    logic [1:0]            cap_off;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [WIDTH-1:0]      rd_q;
    logic                  wr_en_q;
    logic                  mis_q;
    logic [WIDTH-1:0]      src;
    logic [WIDTH-1:0]      aligned;
    logic                  misaligned;
    logic                  trap;

    // Handshake: a transfer happens on a rising edge where ex_valid_in and
    // ex_ready_out are both high; flush_in in the same cycle cancels it.
    assign wb.ex_ready_out   = (state == S_IDLE);
    assign wb.stall_out      = (state == S_WAIT_ACK);
    assign wb.rd_addr_out    = rd_addr_q;
    assign wb.rd_out         = rd_q;
    assign wb.wr_en_out      = wr_en_q;
    assign wb.misaligned_out = mis_q;
    assign state_dbg         = wb_state_t'(state);
    assign trap              = TRAP_EN && misaligned;

    always_comb begin
        src = wb.alu_result_in;
        case (wb.wb_sel_in)
            WB_SEL_IMM: src = wb.imm_in;
            WB_SEL_PC4: src = wb.pc_in + WIDTH'(4);
            default:    src = wb.alu_result_in;
        endcase
    end

    msrv32_load_align #(.WIDTH(WIDTH)) u_align (
        .funct3     (cap_f3),
        .off        (cap_off),
        .rdata      (wb.dm_rdata_in),
        .aligned    (aligned),
        .misaligned (misaligned)
    );

    always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_in) begin
        if (!msrv32_mp_rst_in) begin
            state     <= S_IDLE;
            cap_rd    <= '0;
            cap_wen   <= 1'b0;
            cap_f3    <= '0;
            cap_off   <= '0;
            rd_addr_q <= '0;
            rd_q      <= '0;
            wr_en_q   <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            mis_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wb.ex_valid_in && !wb.flush_in) begin
                        if (wb.wb_sel_in == WB_SEL_LOAD) begin
                            cap_rd  <= wb.rd_addr_in;
                            cap_wen <= wb.rf_wr_en_in;
                            cap_f3  <= wb.load_funct3_in;
                            cap_off <= wb.alu_result_in[1:0];
                            state   <= S_WAIT_ACK;
                        end else begin
                            rd_addr_q <= wb.rd_addr_in;
                            rd_q      <= src;
                            wr_en_q   <= wb.rf_wr_en_in && (wb.rd_addr_in != '0);
                        end
                    end
                end
                default: begin
                    if (wb.flush_in) begin
                        state <= S_IDLE;
                    end else if (wb.dm_ack_in) begin
                        state <= S_IDLE;
                        // A trapped load leaves the register-file outputs untouched.
                        if (trap) begin
                            mis_q <= 1'b1;
                        end else begin
                            rd_addr_q <= cap_rd;
                            rd_q      <= aligned;
                            wr_en_q   <= cap_wen && (cap_rd != '0);
                        end
                    end
                end
            endcase
        end
    end

endmodule
